// File: rtl/decode_format_arbiter.sv
// Per-source FIFOs behind the format decoders, drained one instruction per cycle into a single
// registered output slot using round-robin arbitration over the non-empty FIFOs.
module decode_format_arbiter #(
    parameter int unsigned NumSrc       = 3,
    parameter int unsigned PayloadWidth = 256,
    parameter int unsigned FifoDepth    = 4,
    parameter int unsigned PtrWidth     = 2,
    parameter int unsigned SrcIdWidth   = 2
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic [NumSrc-1:0]              srcValid_i,
    input  logic [NumSrc*PayloadWidth-1:0] srcPayload_i,
    output logic [NumSrc-1:0]              srcStall_o,
    input  logic                           outReady_i,
    output logic                           outValid_o,
    output logic [SrcIdWidth-1:0]          outSrc_o,
    output logic [PayloadWidth-1:0]        outPayload_o,
    output logic                           overflow_o
);

    localparam int unsigned CntWidth = PtrWidth + 1;

    logic [PayloadWidth-1:0] mem_q [NumSrc][FifoDepth];

    logic [PtrWidth-1:0] wr_ptr_q [NumSrc];
    logic [PtrWidth-1:0] wr_ptr_d [NumSrc];
    logic [PtrWidth-1:0] rd_ptr_q [NumSrc];
    logic [PtrWidth-1:0] rd_ptr_d [NumSrc];
    logic [CntWidth-1:0] count_q  [NumSrc];
    logic [CntWidth-1:0] count_d  [NumSrc];

    logic [NumSrc-1:0] stall_q, stall_d;
    logic              overflow_q, overflow_d;

    logic [SrcIdWidth-1:0]   rr_ptr_q, rr_ptr_d;
    logic                    out_valid_q, out_valid_d;
    logic [SrcIdWidth-1:0]   out_src_q, out_src_d;
    logic [PayloadWidth-1:0] out_payload_q, out_payload_d;

    logic [NumSrc-1:0]       non_empty;
    logic [NumSrc-1:0]       push_ok;
    logic [NumSrc-1:0]       pop;
    logic [NumSrc-1:0]       drop;
    logic                    slot_free;
    logic                    grant_valid;
    logic                    grant_fire;
    logic [SrcIdWidth-1:0]   winner;
    logic [SrcIdWidth-1:0]   scan_idx;
    logic [PayloadWidth-1:0] head_payload;

    always_comb begin
        non_empty = '0;
        for (int unsigned s = 0; s < NumSrc; s++) begin
            non_empty[s] = (count_q[s] != '0);
        end
    end

    assign slot_free  = !out_valid_q || outReady_i;
    assign grant_fire = slot_free && grant_valid;

    // Only registered FIFO occupancy is arbitrated; same-edge pushes are not candidates.
    always_comb begin
        grant_valid = 1'b0;
        winner      = '0;
        scan_idx    = '0;
        for (int unsigned i = 0; i < NumSrc; i++) begin
            scan_idx = SrcIdWidth'((32'(rr_ptr_q) + i) % NumSrc);
            if (!grant_valid && non_empty[scan_idx]) begin
                grant_valid = 1'b1;
                winner      = scan_idx;
            end
        end
    end

    always_comb begin
        head_payload = '0;
        for (int unsigned s = 0; s < NumSrc; s++) begin
            if (winner == SrcIdWidth'(s)) begin
                head_payload = mem_q[s][rd_ptr_q[s]];
            end
        end
    end

    // A full FIFO still accepts a push when its head is popped on the same edge.
    always_comb begin
        pop      = '0;
        push_ok  = '0;
        drop     = '0;
        stall_d  = '0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int unsigned s = 0; s < NumSrc; s++) begin
            pop[s]     = grant_fire && (winner == SrcIdWidth'(s));
            push_ok[s] = srcValid_i[s] && ((count_q[s] < CntWidth'(FifoDepth)) || pop[s]);
            drop[s]    = srcValid_i[s] && !push_ok[s];

            if (push_ok[s]) begin
                wr_ptr_d[s] = wr_ptr_q[s] + PtrWidth'(1);
            end
            if (pop[s]) begin
                rd_ptr_d[s] = rd_ptr_q[s] + PtrWidth'(1);
            end

            case ({push_ok[s], pop[s]})
                2'b10:   count_d[s] = count_q[s] + CntWidth'(1);
                2'b01:   count_d[s] = count_q[s] - CntWidth'(1);
                default: count_d[s] = count_q[s];
            endcase

            // Raised one entry early so a source reacting a cycle late still fits.
            stall_d[s] = (count_d[s] >= CntWidth'(FifoDepth - 1));
        end
    end

    assign overflow_d = overflow_q || (|drop);

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        out_valid_d   = out_valid_q;
        out_src_d     = out_src_q;
        out_payload_d = out_payload_q;
        if (slot_free) begin
            out_valid_d = grant_valid;
            if (grant_valid) begin
                out_src_d     = winner;
                out_payload_d = head_payload;
                rr_ptr_d      = (32'(winner) == NumSrc - 1) ? '0 : winner + SrcIdWidth'(1);
            end
        end
    end

    always_ff @(posedge clock_i) begin
        for (int unsigned s = 0; s < NumSrc; s++) begin
            if (push_ok[s]) begin
                mem_q[s][wr_ptr_q[s]] <= srcPayload_i[s*PayloadWidth +: PayloadWidth];
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int unsigned s = 0; s < NumSrc; s++) begin
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
                count_q[s]  <= '0;
            end
            stall_q       <= '0;
            overflow_q    <= 1'b0;
            rr_ptr_q      <= '0;
            out_valid_q   <= 1'b0;
            out_src_q     <= '0;
            out_payload_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            stall_q       <= stall_d;
            overflow_q    <= overflow_d;
            rr_ptr_q      <= rr_ptr_d;
            out_valid_q   <= out_valid_d;
            out_src_q     <= out_src_d;
            out_payload_q <= out_payload_d;
        end
    end

    assign srcStall_o   = stall_q;
    assign overflow_o   = overflow_q;
    assign outValid_o   = out_valid_q;
    assign outSrc_o     = out_src_q;
    assign outPayload_o = out_payload_q;

endmodule

// File: tb/tb_decode_format_arbiter.sv
// Bench for decode_format_arbiter: queue-based reference model checked every cycle, plus
// hand-computed expectations pinned at key points of each directed scenario.
module tb_decode_format_arbiter;

    localparam int unsigned NS = 3;
    localparam int unsigned PW = 256;

    logic               clk;
    logic               reset;
    logic [NS-1:0]      src_valid;
    logic [NS*PW-1:0]   src_payload;
    logic [NS-1:0]      src_stall;
    logic               out_ready;
    logic               out_valid;
    logic [1:0]         out_src;
    logic [PW-1:0]      out_payload;
    logic               overflow;

    decode_format_arbiter #(
        .NumSrc      (3),
        .PayloadWidth(256),
        .FifoDepth   (4),
        .PtrWidth    (2),
        .SrcIdWidth  (2)
    ) dut (
        .clock_i     (clk),
        .reset_i     (reset),
        .srcValid_i  (src_valid),
        .srcPayload_i(src_payload),
        .srcStall_o  (src_stall),
        .outReady_i  (out_ready),
        .outValid_o  (out_valid),
        .outSrc_o    (out_src),
        .outPayload_o(out_payload),
        .overflow_o  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one queue per source, a slot, and a round-robin index.
    logic [PW-1:0] mq [NS][$];
    logic          m_valid;
    int            m_src;
    logic [PW-1:0] m_pay;
    logic          m_ovf;
    logic [NS-1:0] m_stall;
    int            m_rr;

    int            win;
    logic          sfree;
    logic [NS-1:0] acc;
    logic [PW-1:0] head;
    int            cand;

    always @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NS; s++) mq[s].delete();
            m_valid <= 1'b0;
            m_src   <= 0;
            m_pay   <= '0;
            m_ovf   <= 1'b0;
            m_stall <= '0;
            m_rr    <= 0;
        end else begin
            sfree = !m_valid || out_ready;
            win   = -1;
            if (sfree) begin
                for (int k = 0; k < NS; k++) begin
                    cand = (m_rr + k) % NS;
                    if (win < 0 && mq[cand].size() > 0) win = cand;
                end
            end
            for (int s = 0; s < NS; s++) begin
                acc[s] = src_valid[s] && (mq[s].size() < 4 || win == s);
                if (src_valid[s] && !acc[s]) m_ovf <= 1'b1;
            end
            if (win >= 0) begin
                head = mq[win].pop_front();
                m_pay   <= head;
                m_src   <= win;
                m_valid <= 1'b1;
                m_rr    <= (win + 1) % NS;
            end else if (sfree) begin
                m_valid <= 1'b0;
            end
            for (int s = 0; s < NS; s++) begin
                if (acc[s]) mq[s].push_back(src_payload[s*PW +: PW]);
            end
            for (int s = 0; s < NS; s++) m_stall[s] <= (mq[s].size() >= 3);
        end
    end

    int      n_tests = 0;
    int      n_fail  = 0;
    logic    check_en = 1'b0;
    logic    pin_en;
    string   pin_name;
    int      pin_valid, pin_src, pin_stall, pin_ovf, pin_rr;
    longint  pin_pay;

    task automatic cmp(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            cmp("valid", PW'(out_valid), PW'(m_valid));
            cmp("src", PW'(out_src), PW'(m_src));
            cmp("payload", out_payload, m_pay);
            cmp("stall", PW'(src_stall), PW'(m_stall));
            cmp("overflow", PW'(overflow), PW'(m_ovf));
            if (pin_en) begin
                if (pin_valid >= 0) begin
                    cmp({pin_name, ".valid"}, PW'(out_valid), PW'(pin_valid));
                    cmp({pin_name, ".model_valid"}, PW'(m_valid), PW'(pin_valid));
                end
                if (pin_src >= 0) begin
                    cmp({pin_name, ".src"}, PW'(out_src), PW'(pin_src));
                    cmp({pin_name, ".model_src"}, PW'(m_src), PW'(pin_src));
                end
                if (pin_pay >= 0) begin
                    cmp({pin_name, ".payload"}, out_payload, PW'(pin_pay));
                    cmp({pin_name, ".model_payload"}, m_pay, PW'(pin_pay));
                end
                if (pin_stall >= 0) begin
                    cmp({pin_name, ".stall"}, PW'(src_stall), PW'(pin_stall));
                    cmp({pin_name, ".model_stall"}, PW'(m_stall), PW'(pin_stall));
                end
                if (pin_ovf >= 0) begin
                    cmp({pin_name, ".overflow"}, PW'(overflow), PW'(pin_ovf));
                    cmp({pin_name, ".model_overflow"}, PW'(m_ovf), PW'(pin_ovf));
                end
                if (pin_rr >= 0) cmp({pin_name, ".model_rr"}, PW'(m_rr), PW'(pin_rr));
            end
        end
    end

    // Advance one edge; pins set afterwards describe the state that edge produced.
    task automatic tick();
        @(posedge clk);
        #2;
        pin_en    = 1'b0;
        pin_valid = -1;
        pin_src   = -1;
        pin_pay   = -1;
        pin_stall = -1;
        pin_ovf   = -1;
        pin_rr    = -1;
    endtask

    task automatic pin(input string n, input int v, input int s, input longint p, input int st,
                       input int ov);
        pin_en    = 1'b1;
        pin_name  = n;
        pin_valid = v;
        pin_src   = s;
        pin_pay   = p;
        pin_stall = st;
        pin_ovf   = ov;
    endtask

    task automatic set_pay(input int s, input logic [PW-1:0] v);
        src_payload[s*PW +: PW] = v;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        src_valid = 3'b111;
        tick();
        pin("reset", 0, 0, 0, 0, 0);
        pin_rr    = 0;
        reset     = 1'b0;
        src_valid = '0;
    endtask

    logic [NS-1:0] burst_valid [12] = '{3'b101, 3'b111, 3'b011, 3'b000, 3'b110, 3'b111,
                                         3'b100, 3'b001, 3'b111, 3'b000, 3'b010, 3'b000};
    logic          burst_ready [12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                                         1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        reset       = 1'b1;
        src_valid   = 3'b111;
        src_payload = '1;
        out_ready   = 1'b1;
        pin_en      = 1'b0;
        pin_name    = "";
        pin_valid   = -1;
        pin_src     = -1;
        pin_pay     = -1;
        pin_stall   = -1;
        pin_ovf     = -1;
        pin_rr      = -1;

        // Reset with every input active, then release.
        tick();
        check_en = 1'b1;
        pin("t1_reset_a", 0, 0, 0, 0, 0);
        tick();
        pin("t1_reset_b", 0, 0, 0, 0, 0);
        reset     = 1'b0;
        src_valid = '0;
        tick();
        pin("t1_release", 0, 0, 0, 0, 0);

        // Single push on src1.
        src_valid = 3'b010;
        set_pay(1, 256'hAB);
        tick();
        pin("t2_pushed", 0, -1, -1, 0, 0);
        src_valid = '0;
        tick();
        pin("t2_grant", 1, 1, 64'hAB, 0, 0);
        tick();
        pin("t2_idle", 0, 1, 64'hAB, 0, 0);

        // All three push together; grants come out 0, 1, 2.
        do_reset();
        src_valid = 3'b111;
        set_pay(0, 256'h100);
        set_pay(1, 256'h101);
        set_pay(2, 256'h102);
        tick();
        pin("t3_pushed", 0, -1, -1, 0, 0);
        src_valid = '0;
        tick();
        pin("t3_g0", 1, 0, 64'h100, 0, 0);
        tick();
        pin("t3_g1", 1, 1, 64'h101, 0, 0);
        tick();
        pin("t3_g2", 1, 2, 64'h102, 0, 0);
        pin_rr = 0;
        tick();
        pin("t3_idle", 0, 2, 64'h102, 0, 0);

        // Downstream blocked while src0 pushes six times.
        do_reset();
        out_ready = 1'b0;
        src_valid = 3'b001;
        set_pay(0, 256'h200);
        tick();
        pin("t4_e1", 0, -1, -1, 0, 0);
        set_pay(0, 256'h201);
        tick();
        pin("t4_e2", 1, 0, 64'h200, 0, 0);
        set_pay(0, 256'h202);
        tick();
        pin("t4_e3", 1, 0, 64'h200, 0, 0);
        set_pay(0, 256'h203);
        tick();
        pin("t4_e4", 1, 0, 64'h200, 1, 0);
        set_pay(0, 256'h204);
        tick();
        pin("t4_e5", 1, 0, 64'h200, 1, 0);
        set_pay(0, 256'h205);
        tick();
        pin("t4_e6", 1, 0, 64'h200, 1, 1);
        src_valid = '0;
        tick();
        pin("t4_hold", 1, 0, 64'h200, 1, 1);
        out_ready = 1'b1;
        tick();
        pin("t4_d1", 1, 0, 64'h201, 1, 1);
        tick();
        pin("t4_d2", 1, 0, 64'h202, 0, 1);
        tick();
        pin("t4_d3", 1, 0, 64'h203, 0, 1);
        tick();
        pin("t4_d4", 1, 0, 64'h204, 0, 1);
        tick();
        pin("t4_empty", 0, 0, 64'h204, 0, 1);

        // src2 full, pops and pushes on the same edge.
        do_reset();
        out_ready = 1'b0;
        src_valid = 3'b100;
        for (int k = 0; k < 5; k++) begin
            set_pay(2, PW'(32'h300 + k));
            tick();
        end
        pin("t5_full", 1, 2, 64'h300, 3'b100, 0);
        out_ready = 1'b1;
        set_pay(2, 256'h305);
        tick();
        pin("t5_pushpop", 1, 2, 64'h301, 3'b100, 0);
        src_valid = '0;
        tick();
        pin("t5_d1", 1, 2, 64'h302, 3'b100, 0);
        tick();
        pin("t5_d2", 1, 2, 64'h303, 0, 0);
        tick();
        pin("t5_d3", 1, 2, 64'h304, 0, 0);
        tick();
        pin("t5_d4", 1, 2, 64'h305, 0, 0);
        tick();
        pin("t5_empty", 0, 2, 64'h305, 0, 0);

        // Reset while entries are queued and the slot is occupied.
        do_reset();
        out_ready = 1'b0;
        src_valid = 3'b011;
        set_pay(0, 256'h400);
        set_pay(1, 256'h401);
        tick();
        pin("t6_pushed", 0, -1, -1, 0, 0);
        src_valid = 3'b010;
        set_pay(1, 256'h411);
        tick();
        pin("t6_busy", 1, 0, 64'h400, 0, 0);
        reset     = 1'b1;
        src_valid = 3'b111;
        out_ready = 1'b1;
        tick();
        pin("t6_reset", 0, 0, 0, 0, 0);
        reset     = 1'b0;
        src_valid = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            pin("t6_flushed", 0, 0, 0, 0, 0);
        end
        src_valid = 3'b010;
        set_pay(1, 256'h4AA);
        tick();
        pin("t6_fresh_push", 0, 0, 0, 0, 0);
        src_valid = '0;
        tick();
        pin("t6_fresh_grant", 1, 1, 64'h4AA, 0, 0);

        // Mixed contention and backpressure, checked against the model only.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            src_valid = burst_valid[i];
            out_ready = burst_ready[i];
            for (int s = 0; s < NS; s++) set_pay(s, PW'(32'h500 + 16 * i + s));
            tick();
        end
        src_valid = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
